// File: rtl/bch_decode_ctrl.sv
// BCH(15,7) t=2 decoder sequencer: captures a word, strobes the datapath, classifies/corrects, delivers.
// Latency: input handshake at cycle 0 -> out_valid at cycle 3+DP_LAT; one word in flight at a time.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready, no timeout.
module bch_decode_ctrl #(
  parameter int N      = 15,
  parameter int SW     = 4,
  parameter int DP_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_codeword,
  output logic [1:0]        out_status,
  output logic [N-1:0]      dp_codeword,
  output logic              dp_load,
  input  logic [3*SW-1:0]   dp_syndrome,
  input  logic [N-1:0]      dp_error_vector,
  input  logic              dp_error_found,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_total,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorr,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_EVAL, S_OUT} state_t;

  localparam int WCW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_INIT = (DP_LAT > 0) ? WCW'(DP_LAT - 1) : '0;
  localparam int PW = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_CLEAN   = 2'b00;
  localparam logic [1:0] ST_CORR    = 2'b01;
  localparam logic [1:0] ST_UNCORR  = 2'b10;

  state_t           state_q, state_d;
  logic [N-1:0]     cw_q, cw_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [N-1:0]     res_cw_q, res_cw_d;
  logic [1:0]       res_st_q, res_st_d;
  logic [CNT_W-1:0] tot_q, tot_d, corr_q, corr_d, unc_q, unc_d;

  logic             accept;
  logic             out_hs;
  logic [PW-1:0]    err_pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign accept = in_valid && in_ready;
  assign out_hs = (state_q == S_OUT) && out_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; WAIT is bypassed entirely when the datapath is combinational
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = (DP_LAT == 0) ? S_EVAL : S_WAIT;
      S_WAIT:  if (wait_q == '0) state_d = S_EVAL;
      S_EVAL:  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; in_ready is masked by rst_n so it stays low while reset is held
  always_comb begin
    in_ready    = rst_n && (state_q == S_IDLE);
    dp_load     = (state_q == S_LOAD);
    dp_codeword = ((state_q == S_LOAD) || (state_q == S_WAIT) || (state_q == S_EVAL)) ? cw_q : '0;
    out_valid   = (state_q == S_OUT);
    busy        = (state_q != S_IDLE);
  end

  // Number of error locations reported by the Chien search
  always_comb begin
    err_pop = '0;
    for (int i = 0; i < N; i++) err_pop = err_pop + PW'(dp_error_vector[i]);
  end

  // Datapath next-state: capture, wait count, classification and saturating statistics
  always_comb begin
    cw_d     = cw_q;
    wait_d   = wait_q;
    res_cw_d = res_cw_q;
    res_st_d = res_st_q;
    tot_d    = tot_q;
    corr_d   = corr_q;
    unc_d    = unc_q;

    if (accept) cw_d = in_codeword;

    if (state_q == S_LOAD)                         wait_d = WAIT_INIT;
    else if (state_q == S_WAIT && wait_q != '0)    wait_d = wait_q - 1'b1;

    if (state_q == S_EVAL) begin
      if (dp_syndrome == '0) begin
        res_st_d = ST_CLEAN;
        res_cw_d = cw_q;
      end else if (dp_error_found && (err_pop == PW'(1) || err_pop == PW'(2))) begin
        res_st_d = ST_CORR;
        res_cw_d = cw_q ^ dp_error_vector;
      end else begin
        // More than t=2 errors (or a decoder failure): pass the word through untouched
        res_st_d = ST_UNCORR;
        res_cw_d = cw_q;
      end
    end

    // Clear takes priority over an increment in the same cycle
    if (cnt_clear) begin
      tot_d  = '0;
      corr_d = '0;
      unc_d  = '0;
    end else if (out_hs) begin
      tot_d = sat_inc(tot_q);
      if (res_st_q == ST_CORR)   corr_d = sat_inc(corr_q);
      if (res_st_q == ST_UNCORR) unc_d  = sat_inc(unc_q);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q     <= '0;
      wait_q   <= '0;
      res_cw_q <= '0;
      res_st_q <= '0;
      tot_q    <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else begin
      cw_q     <= cw_d;
      wait_q   <= wait_d;
      res_cw_q <= res_cw_d;
      res_st_q <= res_st_d;
      tot_q    <= tot_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
    end
  end

  assign out_codeword  = res_cw_q;
  assign out_status    = res_st_q;
  assign cnt_total     = tot_q;
  assign cnt_corrected = corr_q;
  assign cnt_uncorr    = unc_q;

endmodule

// File: tb/tb_bch_decode_ctrl.sv
// Bench for bch_decode_ctrl: acts as the datapath and the consumer, compares against a reference model.
// Latency: checks out_valid at cycle 3+DP_LAT after each input handshake.
// Backpressure: random out_ready stalls; stray in_valid while busy must not be consumed.
module tb_bch_decode_ctrl;

  localparam int N      = 15;
  localparam int SW     = 4;
  localparam int DP_LAT = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      in_codeword = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N-1:0]      out_codeword;
  logic [1:0]        out_status;
  logic [N-1:0]      dp_codeword;
  logic              dp_load;
  logic [3*SW-1:0]   dp_syndrome = '0;
  logic [N-1:0]      dp_error_vector = '0;
  logic              dp_error_found = 1'b0;
  logic              cnt_clear = 1'b0;
  logic [CNT_W-1:0]  cnt_total;
  logic [CNT_W-1:0]  cnt_corrected;
  logic [CNT_W-1:0]  cnt_uncorr;
  logic              busy;

  int n_chk  = 0;
  int n_pass = 0;
  int m_tot  = 0;
  int m_corr = 0;
  int m_unc  = 0;

  bch_decode_ctrl #(.N(N), .SW(SW), .DP_LAT(DP_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_status(out_status),
    .dp_codeword(dp_codeword), .dp_load(dp_load),
    .dp_syndrome(dp_syndrome), .dp_error_vector(dp_error_vector),
    .dp_error_found(dp_error_found),
    .cnt_clear(cnt_clear), .cnt_total(cnt_total),
    .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_junk();
    dp_syndrome     = 12'($urandom);
    dp_error_vector = 15'($urandom);
    dp_error_found  = 1'($urandom);
  endtask

  task automatic check_counters();
    chk("cnt_total", 32'(cnt_total), m_tot);
    chk("cnt_corrected", 32'(cnt_corrected), m_corr);
    chk("cnt_uncorr", 32'(cnt_uncorr), m_unc);
  endtask

  // One full transaction: source word, act as datapath, stall the consumer, check everything
  task automatic run_word(input logic [N-1:0] cw, input logic [3*SW-1:0] syn,
                          input logic [N-1:0] ev, input logic fnd,
                          input int rdly, input logic clr);
    logic [N-1:0] exp_cw;
    logic [1:0]   exp_st;
    int           cyc;
    int           nerr;
    nerr = $countones(ev);
    if (syn == 0) begin
      exp_st = 2'b00; exp_cw = cw;
    end else if (fnd && (nerr == 1 || nerr == 2)) begin
      exp_st = 2'b01; exp_cw = cw ^ ev;
    end else begin
      exp_st = 2'b10; exp_cw = cw;
    end

    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid    = 1'b1;
    in_codeword = cw;
    drive_junk();
    @(posedge clk);
    @(negedge clk);
    // Stray traffic while busy must be ignored
    in_valid    = 1'($urandom);
    in_codeword = 15'($urandom);
    cyc = 1;
    chk("dp_load", 32'(dp_load), 1);
    chk("dp_codeword", 32'(dp_codeword), 32'(cw));
    chk("in_ready_busy", 32'(in_ready), 0);
    while (!out_valid && cyc < 20) begin
      if (cyc == 2) chk("dp_load_one_cycle", 32'(dp_load), 0);
      if (cyc == DP_LAT + 1) begin
        dp_syndrome     = syn;
        dp_error_vector = ev;
        dp_error_found  = fnd;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 3 + DP_LAT);
    drive_junk();

    for (int i = 0; i < rdly; i++) begin
      chk("stall_codeword", 32'(out_codeword), 32'(exp_cw));
      chk("stall_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 1);
    chk("out_codeword", 32'(out_codeword), 32'(exp_cw));
    chk("out_status", 32'(out_status), 32'(exp_st));
    out_ready = 1'b1;
    cnt_clear = clr;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    cnt_clear = 1'b0;
    in_valid  = 1'b0;
    if (clr) begin
      m_tot = 0; m_corr = 0; m_unc = 0;
    end else begin
      if (m_tot < CMAX) m_tot++;
      if (exp_st == 2'b01 && m_corr < CMAX) m_corr++;
      if (exp_st == 2'b10 && m_unc < CMAX) m_unc++;
    end
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("busy_idle", 32'(busy), 0);
    check_counters();
  endtask

  initial begin
    logic [3*SW-1:0] syn;
    logic [N-1:0]    ev;
    int              k;

    #23;
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", 32'(in_ready), 1);
    check_counters();

    // Reset while the controller is waiting on the datapath
    @(negedge clk);
    in_valid = 1'b1;
    in_codeword = 15'h01D1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_dp_codeword", 32'(dp_codeword), 0);
    chk("rst_dp_load", 32'(dp_load), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_codeword", 32'(out_codeword), 0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 1);
    chk("release_busy", 32'(busy), 0);
    chk("release_out_valid", 32'(out_valid), 0);

    // Known BCH(15,7) cases
    run_word(15'h01D1, 12'h000, 15'h0000, 1'b0, 0, 1'b0);
    run_word(15'h01D0, 12'h3A1, 15'h0001, 1'b1, 1, 1'b0);
    run_word(15'h41D0, 12'h5C7, 15'h4001, 1'b1, 0, 1'b0);
    run_word(15'h01D6, 12'h2B4, 15'h0000, 1'b0, 2, 1'b0);
    run_word(15'h01D6, 12'h2B4, 15'h0007, 1'b1, 0, 1'b0);
    run_word(15'h01D1, 12'h000, 15'h0000, 1'b0, 10, 1'b0);

    // Random traffic; long enough to saturate the narrow counters, with one clear in the middle
    for (int w = 0; w < 50; w++) begin
      k = $urandom_range(0, 3);
      syn = (k == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      ev = '0;
      for (int b = 0; b < $urandom_range(0, 4); b++) ev[$urandom_range(0, N - 1)] = 1'b1;
      run_word(15'($urandom), syn, ev, 1'($urandom_range(0, 3) != 0),
               $urandom_range(0, 3), (w == 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
